// File: rtl/cs_loader_pkg.sv
// Shared definitions for the control store loader: state encoding, default
// widths and the latency-wait preload helper.
package cs_loader_pkg;

    localparam int         CS_ADDR_WIDTH = 8;
    localparam int         CS_DATA_WIDTH = 64;
    localparam logic [7:0] CS_HALT_ADDR  = 8'hFE;
    localparam int         WAIT_WIDTH    = 3;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_C_SETUP = 3'd1,
        ST_C_WRITE = 3'd2,
        ST_C_HOLD  = 3'd3,
        ST_V_SETUP = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    // The wait counter counts down to zero, so a latency of N loads N-1.
    function automatic logic [WAIT_WIDTH-1:0] wait_preload(input int latency);
        return WAIT_WIDTH'(latency - 1);
    endfunction

endpackage

// File: rtl/cs_loader_counter.sv
// Control store address counter: synchronous clear has priority over count
// enable; it never wraps on its own, the FSM clears it at the top address.
module cs_loader_counter
    import cs_loader_pkg::*;
#(
    parameter int WIDTH = CS_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ce,
    output logic [WIDTH-1:0] q,
    output logic             at_max
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ce) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == {WIDTH{1'b1}});

endmodule

// File: rtl/cs_loader.sv
// Copies the microcode EPROM into the control store RAM after reset, optionally
// reads it back for comparison, then hands the control store to the sequencer.
module cs_loader
    import cs_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = CS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = CS_DATA_WIDTH,
    parameter int ROM_LATENCY = 1,
    parameter int VERIFY      = 1
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  reload,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram__w,
    output logic                  busy,
    output logic                  cs_ready,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = wait_preload(ROM_LATENCY);
    localparam logic                  VERIFY_EN = (VERIFY != 0);

    state_e                 state_q,      state_d;
    logic [WAIT_WIDTH-1:0]  wait_q,       wait_d;
    logic [DATA_WIDTH-1:0]  wdata_q,      wdata_d;
    logic                   ram_w_n_q,    ram_w_n_d;
    logic                   busy_q,       busy_d;
    logic                   cs_ready_q,   cs_ready_d;
    logic                   load_error_q, load_error_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q,   err_addr_d;

    logic                   cnt_clr;
    logic                   cnt_ce;
    logic                   cnt_at_max;
    logic [ADDR_WIDTH-1:0]  addr;

    cs_loader_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr (
        .clk    (clk),
        .rst_n  (_reset),
        .clr    (cnt_clr),
        .ce     (cnt_ce),
        .q      (addr),
        .at_max (cnt_at_max)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        wdata_d      = wdata_q;
        load_error_d = load_error_q;
        err_addr_d   = err_addr_q;
        cnt_clr      = 1'b0;
        cnt_ce       = 1'b0;

        unique case (state_q)
            ST_RST: begin
                state_d = ST_C_SETUP;
                wait_d  = WAIT_LOAD;
                cnt_clr = 1'b1;
            end
            ST_C_SETUP: begin
                if (wait_q == '0) begin
                    wdata_d = rom_q;
                    state_d = ST_C_WRITE;
                end else begin
                    wait_d = wait_q - WAIT_WIDTH'(1);
                end
            end
            ST_C_WRITE: begin
                state_d = ST_C_HOLD;
            end
            ST_C_HOLD: begin
                wait_d = WAIT_LOAD;
                if (cnt_at_max) begin
                    cnt_clr = 1'b1;
                    state_d = VERIFY_EN ? ST_V_SETUP : ST_DONE;
                end else begin
                    cnt_ce  = 1'b1;
                    state_d = ST_C_SETUP;
                end
            end
            ST_V_SETUP: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_WIDTH'(1);
                end else if (ram_q != rom_q) begin
                    state_d      = ST_ERROR;
                    load_error_d = 1'b1;
                    err_addr_d   = addr;
                end else if (cnt_at_max) begin
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_ce = 1'b1;
                    wait_d = WAIT_LOAD;
                end
            end
            ST_DONE, ST_ERROR: begin
                // Reload is honoured only here; elsewhere it is simply dropped.
                if (reload) begin
                    state_d      = ST_C_SETUP;
                    wait_d       = WAIT_LOAD;
                    cnt_clr      = 1'b1;
                    load_error_d = 1'b0;
                    err_addr_d   = '0;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // Outputs are registered from the next state so they change with it.
        ram_w_n_d  = (state_d != ST_C_WRITE);
        busy_d     = (state_d inside {ST_C_SETUP, ST_C_WRITE, ST_C_HOLD, ST_V_SETUP});
        cs_ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= ST_RST;
            wait_q       <= '0;
            wdata_q      <= '0;
            ram_w_n_q    <= 1'b1;
            busy_q       <= 1'b0;
            cs_ready_q   <= 1'b0;
            load_error_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            wdata_q      <= wdata_d;
            ram_w_n_q    <= ram_w_n_d;
            busy_q       <= busy_d;
            cs_ready_q   <= cs_ready_d;
            load_error_q <= load_error_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign cs_addr    = addr;
    assign ram_wdata  = wdata_q;
    assign ram__w     = ram_w_n_q;
    assign busy       = busy_q;
    assign cs_ready   = cs_ready_q;
    assign load_error = load_error_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_cs_loader.sv
// Directed bench for cs_loader: instance A (latency 1, verify on) and
// instance B (latency 3, verify off), each with its own ROM/RAM model.
module tb_cs_loader;

    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    int            cyc = 0;
    int            t0  = 0;
    int            n_tests = 0;
    int            n_fail  = 0;

    logic [DW-1:0] rom   [16];
    logic [DW-1:0] ram_a [16];
    logic [DW-1:0] ram_b [16];

    // Instance A signals
    logic          rst_a_n = 1'b0, reload_a = 1'b0, fault_a = 1'b0;
    logic [DW-1:0] rom_q_a, ram_q_a, ram_wdata_a;
    logic [AW-1:0] cs_addr_a, err_addr_a;
    logic          ram_w_a_n, busy_a, cs_ready_a, load_error_a;

    // Instance B signals
    logic          rst_b_n = 1'b0, reload_b = 1'b0;
    logic [DW-1:0] rom_q_b, ram_q_b, ram_wdata_b;
    logic [AW-1:0] cs_addr_b, err_addr_b;
    logic          ram_w_b_n, busy_b, cs_ready_b, load_error_b;
    logic [AW-1:0] addr_b_p1 = '0, addr_b_p2 = '0;

    int strobes_a = 0, strobes_b = 0;
    int va_consec = 0, va_addr = 0, va_rb = 0;
    int vb_consec = 0, vb_addr = 0, vb_rb = 0, vb_run = 0, nb_pulses = 0;
    logic          pa_valid = 1'b0, pa_w = 1'b1;
    logic [AW-1:0] pa_addr = '0;
    logic          pb_valid = 1'b0, pb_w = 1'b1;
    logic [AW-1:0] pb_addr = '0;
    int            run_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1), .VERIFY(1)) u_dut_a (
        .clk(clk), ._reset(rst_a_n), .reload(reload_a), .rom_q(rom_q_a), .ram_q(ram_q_a),
        .cs_addr(cs_addr_a), .ram_wdata(ram_wdata_a), .ram__w(ram_w_a_n), .busy(busy_a),
        .cs_ready(cs_ready_a), .load_error(load_error_a), .err_addr(err_addr_a)
    );

    cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3), .VERIFY(0)) u_dut_b (
        .clk(clk), ._reset(rst_b_n), .reload(reload_b), .rom_q(rom_q_b), .ram_q(ram_q_b),
        .cs_addr(cs_addr_b), .ram_wdata(ram_wdata_b), .ram__w(ram_w_b_n), .busy(busy_b),
        .cs_ready(cs_ready_b), .load_error(load_error_b), .err_addr(err_addr_b)
    );

    // Latency 1: data valid before the first edge after the address changes.
    assign rom_q_a = rom[cs_addr_a];
    assign ram_q_a = ram_a[cs_addr_a] ^ ((fault_a && cs_addr_a == 4'h9) ? 64'h20 : 64'h0);
    // Latency 3: two register stages ahead of the array lookup.
    always @(posedge clk) begin
        addr_b_p1 <= cs_addr_b;
        addr_b_p2 <= addr_b_p1;
    end
    assign rom_q_b = rom[addr_b_p2];
    assign ram_q_b = ram_b[addr_b_p2];

    always @(posedge clk) begin
        if (!ram_w_a_n) begin
            ram_a[cs_addr_a] <= ram_wdata_a;
            strobes_a++;
        end
        if (!ram_w_b_n) begin
            ram_b[cs_addr_b] <= ram_wdata_b;
            strobes_b++;
        end
    end

    // Protocol monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_a_n) begin
            pa_valid = 1'b0;
        end else begin
            if (pa_valid) begin
                if (!pa_w && !ram_w_a_n) va_consec++;
                if ((!pa_w || !ram_w_a_n) && cs_addr_a != pa_addr) va_addr++;
            end
            pa_valid = 1'b1;
            pa_w     = ram_w_a_n;
            pa_addr  = cs_addr_a;
        end
        if (cs_ready_a && busy_a) va_rb++;
    end

    always @(negedge clk) begin
        if (!rst_b_n) begin
            pb_valid = 1'b0;
            run_b    = 0;
        end else begin
            if (pb_valid) begin
                if (!pb_w && !ram_w_b_n) vb_consec++;
                if ((!pb_w || !ram_w_b_n) && cs_addr_b != pb_addr) vb_addr++;
            end
            if (!ram_w_b_n) begin
                if (cs_addr_b != '0) begin
                    nb_pulses++;
                    if (run_b != 3) vb_run++;
                end
            end else if (pb_valid && cs_addr_b == pb_addr) begin
                run_b++;
            end else begin
                run_b = 1;
            end
            pb_valid = 1'b1;
            pb_w     = ram_w_b_n;
            pb_addr  = cs_addr_b;
        end
        if (cs_ready_b && busy_b) vb_rb++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int diff_words(input logic [DW-1:0] m [16]);
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i] !== rom[i]) n++;
        return n;
    endfunction

    function automatic logic flag(input int id);
        case (id)
            0:       return cs_ready_a;
            1:       return load_error_a;
            default: return cs_ready_b;
        endcase
    endfunction

    // Returns edges since t0 when the flag is seen, or the limit on timeout.
    task automatic wait_flag(input int id, input int limit, output int edges);
        while (!flag(id) && (cyc - t0) < limit) begin
            @(posedge clk);
            #1;
        end
        edges = cyc - t0;
    endtask

    // Reload is sampled on edge t0+1.
    task automatic pulse_reload_a();
        @(negedge clk);
        reload_a = 1'b1;
        t0       = cyc;
        strobes_a = 0;
        @(negedge clk);
        reload_a = 1'b0;
    endtask

    int  edges;
    logic found;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom[i]   = 64'(i) * 64'h0101_0101_0101_0101;
            ram_a[i] = '0;
            ram_b[i] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs_addr",    64'(cs_addr_a),    64'h0);
        check("rst_ram_wdata",  ram_wdata_a,       64'h0);
        check("rst_ram_w",      64'(ram_w_a_n),    64'h1);
        check("rst_busy",       64'(busy_a),       64'h0);
        check("rst_cs_ready",   64'(cs_ready_a),   64'h0);
        check("rst_load_error", 64'(load_error_a), 64'h0);
        check("rst_err_addr",   64'(err_addr_a),   64'h0);

        // Test 1: copy and verify after reset release
        rst_a_n   = 1'b1;
        t0        = cyc;
        strobes_a = 0;
        @(posedge clk);
        #1;
        check("t1_busy_edge1",  64'(busy_a),     64'h1);
        check("t1_ready_edge1", 64'(cs_ready_a), 64'h0);
        wait_flag(0, 200, edges);
        check("t1_ready_edge", 64'(edges), 64'd65);
        check("t1_strobes",    64'(strobes_a), 64'd16);
        check("t1_ram_image",  64'(diff_words(ram_a)), 64'd0);
        check("t1_load_error", 64'(load_error_a), 64'h0);
        check("t1_busy_done",  64'(busy_a), 64'h0);
        check("t1_addr_done",  64'(cs_addr_a), 64'h0);

        // Test 5: reload in DONE forces a recopy; reload during C_SETUP is ignored
        for (int i = 0; i < 16; i++) ram_a[i] = '0;
        pulse_reload_a();
        check("t5_ready_drop", 64'(cs_ready_a), 64'h0);
        check("t5_busy",       64'(busy_a),     64'h1);
        check("t5_addr0",      64'(cs_addr_a),  64'h0);
        reload_a = 1'b1;
        @(negedge clk);
        reload_a = 1'b0;
        wait_flag(0, 200, edges);
        check("t5_ready_edge", 64'(edges), 64'd65);
        check("t5_strobes",    64'(strobes_a), 64'd16);
        check("t5_ram_image",  64'(diff_words(ram_a)), 64'd0);

        // Test 2: read-back fault at 0x9 on bit 5
        fault_a = 1'b1;
        pulse_reload_a();
        wait_flag(1, 200, edges);
        check("t2_error_edge", 64'(edges), 64'd59);
        check("t2_load_error", 64'(load_error_a), 64'h1);
        check("t2_err_addr",   64'(err_addr_a),   64'h9);
        check("t2_busy",       64'(busy_a),       64'h0);
        repeat (5) @(negedge clk);
        check("t2_ready_low",  64'(cs_ready_a),   64'h0);
        check("t2_sticky",     64'(load_error_a), 64'h1);
        fault_a = 1'b0;
        pulse_reload_a();
        check("t2_err_clear",  64'(load_error_a), 64'h0);
        check("t2_addr_clear", 64'(err_addr_a),   64'h0);
        check("t2_busy_again", 64'(busy_a),       64'h1);
        wait_flag(0, 200, edges);
        check("t2_ready_edge", 64'(edges), 64'd65);
        check("t2_final_err",  64'(load_error_a), 64'h0);

        // Test 4: reset dropped during the write of word 0x7
        pulse_reload_a();
        found = 1'b0;
        while (!found && (cyc - t0) < 200) begin
            @(posedge clk);
            #1;
            found = (cs_addr_a == 4'h7) && !ram_w_a_n;
        end
        check("t4_reach_w7", 64'(found), 64'h1);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("t4_async_w",    64'(ram_w_a_n), 64'h1);
        check("t4_async_addr", 64'(cs_addr_a), 64'h0);
        check("t4_async_busy", 64'(busy_a),    64'h0);
        for (int i = 0; i < 16; i++) ram_a[i] = '0;
        repeat (2) @(negedge clk);
        rst_a_n   = 1'b1;
        t0        = cyc;
        strobes_a = 0;
        wait_flag(0, 200, edges);
        check("t4_ready_edge", 64'(edges), 64'd65);
        check("t4_strobes",    64'(strobes_a), 64'd16);
        check("t4_ram_image",  64'(diff_words(ram_a)), 64'd0);

        // Test 3: latency 3, no verify pass
        @(negedge clk);
        rst_b_n   = 1'b1;
        t0        = cyc;
        strobes_b = 0;
        wait_flag(2, 300, edges);
        check("t3_ready_edge", 64'(edges), 64'd81);
        check("t3_strobes",    64'(strobes_b), 64'd16);
        check("t3_ram_image",  64'(diff_words(ram_b)), 64'd0);
        check("t3_load_error", 64'(load_error_b), 64'h0);
        check("t3_pulses",     64'(nb_pulses), 64'd15);
        check("t3_setup_run",  64'(vb_run), 64'd0);

        // Test 6: protocol monitor totals
        repeat (3) @(negedge clk);
        check("t6_a_consec_w",   64'(va_consec), 64'd0);
        check("t6_a_addr_moved", 64'(va_addr),   64'd0);
        check("t6_a_ready_busy", 64'(va_rb),     64'd0);
        check("t6_b_consec_w",   64'(vb_consec), 64'd0);
        check("t6_b_addr_moved", 64'(vb_addr),   64'd0);
        check("t6_b_ready_busy", 64'(vb_rb),     64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
